// File: rtl/sparse_match_scanner_pkg.sv
// Shared types and helpers for the sparse match scanner and the prefix-sum block.
// SPARSE_SCAN_CNT_EN (defined by the build) enables the per-chunk match count port.
package sparse_scan_pkg;

    localparam int POP_MAX_W = 1024;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    function automatic int lanes_idx(input int k, input int aw);
        return k * aw;
    endfunction

    // Callers zero-extend their bitmap to POP_MAX_W bits.
    function automatic int popcount(input logic [POP_MAX_W-1:0] vec);
        int cnt;
        cnt = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            cnt += int'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sparse_match_scanner_match_pick.sv
// Combinational lowest-set-bit finder; returns the bit index and the vector
// with that bit removed so several instances can be chained.
module match_pick #(
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic             o_found,
    output logic [AW-1:0]    o_idx,
    output logic [WIDTH-1:0] o_cleared
);

    // Scan downward so the last assignment wins with the lowest set bit.
    always_comb begin
        o_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = AW'(i);
            end
        end
    end

    assign o_found   = |i_vec;
    assign o_cleared = i_vec & (i_vec - WIDTH'(1));

endmodule

// File: rtl/sparse_match_scanner.sv
// Streams ascending indices of (ifm & fil) matches, LANES per beat, per chunk.
// SPARSE_SCAN_CNT_EN adds match_cnt_o, the registered popcount of the chunk.
module sparse_match_scanner
    import sparse_scan_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int LANES = 2,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [WIDTH-1:0]    ifm_i,
    input  logic [WIDTH-1:0]    fil_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [LANES*AW-1:0] out_addr_o,
    output logic [LANES-1:0]    out_mask_o,
    output logic                out_last_o
`ifdef SPARSE_SCAN_CNT_EN
    ,
    output logic [AW:0]         match_cnt_o
`endif
);

    scan_state_e      r_state;
    logic [WIDTH-1:0] r_pending;

    logic [WIDTH-1:0] w_stage [LANES+1];
    logic [AW-1:0]    w_idx   [LANES];
    logic [LANES-1:0] w_found;
    logic             w_scan;
    logic             w_last;
    logic             w_beat;
    logic             w_accept;

    assign w_stage[0] = r_pending;

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            match_pick #(.WIDTH(WIDTH)) u_pick (
                .i_vec    (w_stage[k]),
                .o_found  (w_found[k]),
                .o_idx    (w_idx[k]),
                .o_cleared(w_stage[k+1])
            );
            assign out_addr_o[lanes_idx(k, AW) +: AW] = (w_scan && w_found[k]) ? w_idx[k] : '0;
        end
    endgenerate

    // A beat is last when nothing survives after removing this beat's lanes.
    assign w_scan      = (r_state == SCAN);
    assign w_last      = w_scan && (w_stage[LANES] == '0);
    assign w_beat      = w_scan && out_ready_i;
    assign w_accept    = in_valid_i && in_ready_o;

    assign out_valid_o = w_scan;
    assign out_last_o  = w_last;
    assign out_mask_o  = w_scan ? w_found : '0;
    assign in_ready_o  = !w_scan || (w_beat && w_last);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_pending <= '0;
        end else if (w_accept) begin
            r_state   <= SCAN;
            r_pending <= ifm_i & fil_i;
        end else if (w_beat) begin
            r_pending <= w_stage[LANES];
            if (w_last) begin
                r_state <= IDLE;
            end
        end
    end

`ifdef SPARSE_SCAN_CNT_EN
    logic [AW:0] r_match_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_match_cnt <= '0;
        end else if (w_accept) begin
            r_match_cnt <= (AW+1)'(popcount(POP_MAX_W'(ifm_i & fil_i)));
        end
    end

    assign match_cnt_o = r_match_cnt;
`endif

endmodule

// File: doc/sparse_match_scanner.md
# sparse_match_scanner

Parametrised successor to the single-match priority encoder stage. Per chunk, it ANDs an IFM non-zero bitmap with a filter non-zero bitmap. It then streams the indices of the matching positions, up to LANES indices per beat in ascending order, over valid/ready handshakes. It sits between the bitmap fetch logic and the prefix-sum/MAC address generators. It adds chunk-level flow control, multi-lane extraction and explicit empty-chunk signalling.

## Interface
- WIDTH, 64, bitmap width per chunk (power of two, ≥ 4)
- LANES, 2, match indices emitted per beat (1..8, ≤ WIDTH)
- AW, $clog2(WIDTH), derived index width (localparam, not overridable)

- clk_i  input  1  clock; all state updates on rising edge
- rst_ni  input  1  asynchronous, active-low reset
- in_valid_i  input  1  chunk bitmaps valid
- in_ready_o  output  1  block can accept a chunk this cycle
- ifm_i  input  WIDTH  IFM non-zero bitmap
- fil_i  input  WIDTH  filter non-zero bitmap
- out_valid_o  output  1  beat valid
- out_ready_i  input  1  consumer accepts beat
- out_addr_o  output  LANES*AW  lane k index in bits [k*AW +: AW]
- out_mask_o  output  LANES  lane k carries a valid index
- out_last_o  output  1  final beat of current chunk
- match_cnt_o  output  AW+1  total matches in chunk (only with SPARSE_SCAN_CNT_EN)

## Operation
- State machine IDLE / SCAN; pending_r[WIDTH] holds unconsumed matches.
- IDLE: in_ready_o=1, out_valid_o=0. When in_valid_i is high, pending_r <= ifm_i & fil_i and the state goes to SCAN.
- SCAN: out_valid_o=1. Lane 0 carries the lowest set bit of pending_r, lane 1 the next, and so on. Lanes with no bit have mask 0 and addr 0.
- out_last_o=1 when popcount(pending_r) ≤ LANES.
- Beat handshake (out_valid_o & out_ready_i): the emitted bits are cleared from pending_r.
- If the beat was last and no new chunk is accepted, the state returns to IDLE.
- Empty chunk (AND = 0): exactly one beat, out_mask_o=0, out_last_o=1.
- Back-to-back: in_ready_o = IDLE | (out_valid_o & out_ready_i & out_last_o). A chunk accepted in the same cycle as the last-beat handshake loads pending_r directly, and the state stays in SCAN (zero bubble).
- Back-pressure: while out_valid_o & !out_ready_i, all outputs are held stable. pending_r and the state do not change.
- in_valid_i in SCAN without the last handshake is ignored; the upstream must hold it.
- Full chunk (all WIDTH bits set): exactly ceil(WIDTH/LANES) beats.

## Timing
- Reset (async assert, sync deassert expected): state=IDLE, pending_r=0, out_valid_o=0, out_last_o=0, out_mask_o=0, out_addr_o=0, in_ready_o=1, match_cnt_o=0.
- Reset mid-chunk: the remaining matches are discarded and no further beats are issued.
- Latency: first beat valid the cycle after the accept. Outputs are driven from registers plus pick logic on pending_r only; there is no combinational path from in_*_i to out_*_o.
- Throughput: one beat per cycle with out_ready_i held high. A chunk with M matches occupies max(1, ceil(M/LANES)) cycles.

## Configuration
- SPARSE_SCAN_CNT_EN defined:
  - match_cnt_o exists and is registered at chunk accept as popcount(ifm_i & fil_i).
  - It is held for the whole chunk and is valid whenever out_valid_o=1; it is 0 in IDLE after reset.
  - A full chunk gives WIDTH, which is why the port is AW+1 bits wide.
- Undefined: the port and the popcount logic are absent. All other behaviour is identical.

## Structure
- Package sparse_scan_pkg holds:
  - the scan_state_e typedef (IDLE, SCAN);
  - function lanes_idx(k, AW) for slicing out_addr_o;
  - a popcount function shared with the prefix-sum block.
- Sub-module match_pick (parameter WIDTH):
  - combinational lowest-set-bit finder with outputs found, idx[AW] and cleared vector;
  - chained LANES times to build the lane outputs and the next pending value.

## Test plan
- WIDTH=8, LANES=2; ifm=8'b1011_0110, fil=8'b1110_0011 (AND 1010_0010) → beat1 addr{5,1} mask 2'b11 last 0; beat2 lane0=7 mask 2'b01 last 1; match_cnt_o=3.
- ifm=8'hF0, fil=8'h0F → single beat, mask 2'b00, last 1, match_cnt_o=0; state back to IDLE next cycle.
- ifm=fil=8'hFF, out_ready_i toggling 1,0,1,0 → 4 beats {1,0},{3,2},{5,4},{7,6}; outputs stable during stall cycles; last only on {7,6}.
- Two chunks presented back-to-back (8'h81 then 8'h02, fil=8'hFF) with out_ready_i=1 → beats {7,0} last, then {1} last on the immediately next cycle, no bubble.
- rst_ni pulsed low for half a cycle during beat 2 of an 8'hFF chunk → out_valid_o falls immediately; in_ready_o=1; no further beats.
- WIDTH=64, LANES=4, random bitmaps × 1000 → the emitted index set equals the AND bit positions, ascending, with no duplicates and exactly one last per chunk.
